// File: rtl/evr_sroc_multi_if.sv
// Configuration and status bundle for evr_sroc_multi.
// The bench drives the master side; the clock generator sits on the slave side.
interface evr_sroc_multi_if #(
  parameter int NCHAN         = 4,
  parameter int DIVISOR_WIDTH = 10,
  parameter int PHASE_WIDTH   = 10,
  parameter int HB_UPPER      = 137500000
);
  localparam int CHAN_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int HB_CNT_W = $clog2(HB_UPPER + 1);

  logic                     cfgWrite;
  logic [CHAN_W-1:0]        cfgChan;
  logic [DIVISOR_WIDTH-1:0] cfgDivisor;
  logic [PHASE_WIDTH-1:0]   cfgPhase;
  logic [NCHAN-1:0]         srocOut;
  logic [NCHAN-1:0]         srocStrobe;
  logic [NCHAN-1:0]         srocSynced;
  logic                     hbValid;
  logic [HB_CNT_W-1:0]      hbPeriod;

  modport master (
    output cfgWrite, cfgChan, cfgDivisor, cfgPhase,
    input  srocOut, srocStrobe, srocSynced, hbValid, hbPeriod
  );

  modport slave (
    input  cfgWrite, cfgChan, cfgDivisor, cfgPhase,
    output srocOut, srocStrobe, srocSynced, hbValid, hbPeriod
  );
endinterface

// File: rtl/evr_sroc_multi.sv
// Multi-channel EVR orbit-clock generator with heartbeat alignment and period watchdog.
// Define EVR_SROC_PHASE_EN to delay each channel's alignment by its programmed phase offset.
module evr_sroc_multi #(
  parameter int NCHAN           = 4,
  parameter int DIVISOR_WIDTH   = 10,
  parameter int PHASE_WIDTH     = 10,
  parameter int DEFAULT_DIVISOR = 0,
  parameter int HB_LOWER        = 112500000,
  parameter int HB_UPPER        = 137500000
) (
  input  logic           evrClk,
  input  logic           evrReset_n,
  input  logic           evrHeartbeat,
  evr_sroc_multi_if.slave bus
);
  localparam int CHAN_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int HB_CNT_W = $clog2(HB_UPPER + 1);
  localparam logic [HB_CNT_W-1:0] HB_LO = HB_CNT_W'(HB_LOWER);
  localparam logic [HB_CNT_W-1:0] HB_HI = HB_CNT_W'(HB_UPPER);

  logic                     hb_d;
  logic                     hb_edge;
  logic                     cfg_hit;
  logic [DIVISOR_WIDTH-1:0] div_q [NCHAN];
  logic [DIVISOR_WIDTH-1:0] cnt_q [NCHAN];
  logic [DIVISOR_WIDTH-1:0] r_hi  [NCHAN];
  logic [DIVISOR_WIDTH-1:0] r_lo  [NCHAN];
  logic [NCHAN-1:0]         out_q;
  logic [NCHAN-1:0]         strobe_q;
  logic [NCHAN-1:0]         synced_q;
  logic [NCHAN-1:0]         enabled;
  logic [NCHAN-1:0]         align;
  logic [HB_CNT_W-1:0]      wd_q;
  logic [HB_CNT_W-1:0]      period_q;
  logic                     valid_q;

  assign hb_edge = evrHeartbeat & ~hb_d;
  assign cfg_hit = bus.cfgWrite && (int'(bus.cfgChan) < NCHAN);

  always_ff @(posedge evrClk) begin
    if (!evrReset_n) hb_d <= 1'b0;
    else             hb_d <= evrHeartbeat;
  end

  always_ff @(posedge evrClk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (!evrReset_n)
        div_q[c] <= DIVISOR_WIDTH'(DEFAULT_DIVISOR);
      else if (cfg_hit && bus.cfgChan == CHAN_W'(c))
        div_q[c] <= bus.cfgDivisor;
    end
  end

  // ((D+1)>>1)-1 rewritten as (D>>1)+D[0]-1 so it never needs an extra bit
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      enabled[c] = (div_q[c] >= DIVISOR_WIDTH'(2));
      r_hi[c]    = (div_q[c] >> 1) - DIVISOR_WIDTH'(1);
      r_lo[c]    = (div_q[c] >> 1) + DIVISOR_WIDTH'(div_q[c][0]) - DIVISOR_WIDTH'(1);
    end
  end

`ifdef EVR_SROC_PHASE_EN
  logic [PHASE_WIDTH-1:0] phase_q [NCHAN];
  logic [PHASE_WIDTH-1:0] pc_q    [NCHAN];

  always_ff @(posedge evrClk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (!evrReset_n) begin
        phase_q[c] <= '0;
        pc_q[c]    <= '0;
      end else begin
        if (cfg_hit && bus.cfgChan == CHAN_W'(c))
          phase_q[c] <= bus.cfgPhase;
        if (!enabled[c])
          pc_q[c] <= '0;
        else if (hb_edge)
          pc_q[c] <= phase_q[c];
        else if (pc_q[c] != '0)
          pc_q[c] <= pc_q[c] - PHASE_WIDTH'(1);
      end
    end
  end

  // A running phase count expiring still aligns even if a fresh marker restarts it
  always_comb begin
    for (int c = 0; c < NCHAN; c++)
      align[c] = (pc_q[c] == PHASE_WIDTH'(1)) || (hb_edge && phase_q[c] == '0);
  end
`else
  logic unused_phase;
  assign unused_phase = ^bus.cfgPhase;
  assign align        = {NCHAN{hb_edge}};
`endif

  always_ff @(posedge evrClk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (!evrReset_n || !enabled[c]) begin
        out_q[c]    <= 1'b0;
        strobe_q[c] <= 1'b0;
        synced_q[c] <= 1'b0;
        cnt_q[c]    <= '0;
      end else if (align[c]) begin
        synced_q[c] <= !out_q[c] && (cnt_q[c] == '0);
        out_q[c]    <= 1'b1;
        cnt_q[c]    <= r_hi[c];
        strobe_q[c] <= 1'b1;
      end else if (cnt_q[c] != '0) begin
        cnt_q[c]    <= cnt_q[c] - DIVISOR_WIDTH'(1);
        strobe_q[c] <= 1'b0;
      end else if (out_q[c]) begin
        out_q[c]    <= 1'b0;
        cnt_q[c]    <= r_lo[c];
        strobe_q[c] <= 1'b0;
      end else begin
        out_q[c]    <= 1'b1;
        cnt_q[c]    <= r_hi[c];
        strobe_q[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge evrClk) begin
    if (!evrReset_n) begin
      wd_q     <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else if (hb_edge) begin
      period_q <= wd_q;
      valid_q  <= (wd_q > HB_LO) && (wd_q < HB_HI);
      wd_q     <= HB_CNT_W'(1);
    end else begin
      if (wd_q != HB_HI) wd_q <= wd_q + HB_CNT_W'(1);
      if (wd_q == HB_HI) valid_q <= 1'b0;
    end
  end

  assign bus.srocOut    = out_q;
  assign bus.srocStrobe = strobe_q;
  assign bus.srocSynced = synced_q;
  assign bus.hbValid    = valid_q;
  assign bus.hbPeriod   = period_q;
endmodule
